// File: rtl/minirv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data SRAM between the
// miniRV CPU (port 0) and the loader/debug master (port 1). Define MEM_ARB_ERR_EN for rsp_err.
module minirv_mem_arbiter #(
   parameter int unsigned AW        = 6,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    req_valid,
   output logic [1:0]    req_ready,
   input  logic [63:0]   req_addr,
   input  logic [63:0]   req_wdata,
   input  logic [7:0]    req_wstrb,
   output logic [1:0]    rsp_valid,
   output logic [31:0]   rsp_rdata,
`ifdef MEM_ARB_ERR_EN
   output logic [1:0]    rsp_err,
`endif
   output logic          mem_en,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_wstrb,
   input  logic [31:0]   mem_rdata
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   // Window size in bytes, one bit wider so AW up to 30 cannot overflow.
   localparam logic [32:0] Span = 33'd4 << AW;

   state_e        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          grant_q, grant_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic          in_range_q, in_range_d;

   logic          win;
   logic [31:0]   sel_addr;
   logic [31:0]   offset;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         idx_q        <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         in_range_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         idx_q        <= idx_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         in_range_q   <= in_range_d;
      end
   end

   always_comb begin
      // On a tie the port that did not win last time is served.
      win      = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
      sel_addr = win ? req_addr[63:32] : req_addr[31:0];
      offset   = sel_addr - BASE_ADDR;

      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      idx_d        = idx_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      in_range_d   = in_range_q;

      req_ready = 2'b00;
      rsp_valid = 2'b00;
      rsp_rdata = 32'h0;
`ifdef MEM_ARB_ERR_EN
      rsp_err   = 2'b00;
`endif
      mem_en    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 32'h0;
      mem_wstrb = 4'h0;

      unique case (state_q)
         StIdle: begin
            if (rst_n && (req_valid != 2'b00)) begin
               req_ready[win] = 1'b1;
               state_d        = StAccess;
               grant_d        = win;
               last_grant_d   = win;
               idx_d          = offset[AW+1:2];
               wdata_d        = win ? req_wdata[63:32] : req_wdata[31:0];
               wstrb_d        = win ? req_wstrb[7:4] : req_wstrb[3:0];
               in_range_d     = ({1'b0, offset} < Span);
            end
         end
         StAccess: begin
            state_d   = StResp;
            mem_en    = in_range_q;
            mem_addr  = idx_q;
            mem_wdata = wdata_q;
            mem_wstrb = wstrb_q;
         end
         StResp: begin
            state_d            = StIdle;
            rsp_valid[grant_q] = 1'b1;
            if (in_range_q && (wstrb_q == 4'h0)) begin
               rsp_rdata = mem_rdata;
            end
`ifdef MEM_ARB_ERR_EN
            rsp_err[grant_q] = ~in_range_q;
`endif
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_minirv_mem_arbiter.sv
// Self-checking bench for minirv_mem_arbiter: directed vector table, tie/reset sequences and
// randomized traffic against a transaction-level reference model.
module tb_minirv_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_wstrb = '0;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
`ifdef MEM_ARB_ERR_EN
   logic [1:0]  rsp_err;
`endif
   logic        mem_en;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   minirv_mem_arbiter #(.AW(6), .BASE_ADDR(32'h0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
`ifdef MEM_ARB_ERR_EN
      .rsp_err   (rsp_err),
`endif
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata)
   );

   // SRAM model with a backdoor write port for preloading.
   logic [31:0] sram [64];
   logic        bd_we = 1'b0;
   logic [5:0]  bd_addr = '0;
   logic [31:0] bd_data = '0;

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] strb);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (bd_we) sram[bd_addr] <= bd_data;
      else if (mem_en) begin
         mem_rdata <= sram[mem_addr];
         sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_wstrb);
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic preload(int a, logic [31:0] d);
      @(posedge clk); #1;
      bd_we = 1'b1; bd_addr = 6'(a); bd_data = d;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   task automatic set_port(int p, logic v, logic [31:0] a, logic [31:0] d, logic [3:0] s);
      req_valid[p]         = v;
      req_addr[32*p +: 32] = a;
      req_wdata[32*p +: 32] = d;
      req_wstrb[4*p +: 4]  = s;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      set_port(0, 1'b1, 32'h4, 32'h1, 4'hF);
      set_port(1, 1'b1, 32'h8, 32'h2, 4'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
      @(negedge clk);
      req_valid = 2'b00;
      rst_n = 1'b1;
   endtask

   // One isolated request; DUT must be idle (or finishing RESP) on entry.
   task automatic do_txn(string nm, int p, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                         bit in_rng, logic [31:0] exp_rd);
      logic [1:0] oh = (p == 0) ? 2'b01 : 2'b10;
      @(posedge clk); #1;
      set_port(p, 1'b1, a, d, s);
      @(negedge clk);
      chk({nm, "_ready"}, 32'(req_ready), 32'(oh));
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk({nm, "_mem_en"}, 32'(mem_en), 32'(in_rng));
      if (in_rng) begin
         chk({nm, "_mem_addr"}, 32'(mem_addr), (a >> 2) & 32'h3F);
         chk({nm, "_mem_wstrb"}, 32'(mem_wstrb), 32'(s));
      end
      chk({nm, "_busy_ready"}, 32'(req_ready), 32'h0);
      chk({nm, "_early_rsp"}, 32'(rsp_valid), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
      chk({nm, "_rsp_rdata"}, rsp_rdata, exp_rd);
`ifdef MEM_ARB_ERR_EN
      chk({nm, "_rsp_err"}, 32'(rsp_err), in_rng ? 32'h0 : 32'(oh));
`endif
   endtask

   typedef struct {
      int          port;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      bit          in_rng;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      int          due;
      int          port;
      logic [31:0] rdata;
   } rsp_t;

   initial begin
      vec_t        tbl[10];
      rsp_t        rq[$];
      rsp_t        r;
      logic [31:0] ref_mem [64];
      bit          pv[2];
      logic [31:0] pa[2], pd[2];
      logic [3:0]  ps[2];
      int          next_free, ref_last, w, ng, nr;
      int          g_port[$], g_cyc[$], r_port[$], r_cyc[$];
      logic [31:0] r_data[$];
      logic [1:0]  exp_v, exp_r;
      logic [31:0] exp_d;

      tbl[0] = '{0, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'h1234_5678};
      tbl[1] = '{0, 32'h0000_0000, 32'h90AB_CDEF, 4'hF, 1'b1, 32'h0};
      tbl[2] = '{1, 32'h0000_0001, 32'hABAB_ABAB, 4'h2, 1'b1, 32'h0};
      tbl[3] = '{1, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'h90AB_ABEF};
      tbl[4] = '{0, 32'h0000_0100, 32'h0,         4'h0, 1'b0, 32'h0};
      tbl[5] = '{1, 32'h0000_0104, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
      tbl[6] = '{0, 32'h0000_0004, 32'h0,         4'h0, 1'b1, 32'h0BAD_F00D};
      tbl[7] = '{1, 32'h0000_00FF, 32'hCAFE_0000, 4'hC, 1'b1, 32'h0};
      tbl[8] = '{0, 32'h0000_00FC, 32'h0,         4'h0, 1'b1, 32'hCAFE_1234};
      tbl[9] = '{1, 32'hFFFF_FFFC, 32'h0,         4'h0, 1'b0, 32'h0};

      do_reset();
      preload(0, 32'h1234_5678);
      preload(1, 32'h0BAD_F00D);
      preload(63, 32'h0000_1234);
      for (int i = 0; i < 10; i++)
         do_txn($sformatf("vec%0d", i), tbl[i].port, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb,
                tbl[i].in_rng, tbl[i].rdata);

      // Both ports requesting continuously from reset: grants alternate 0,1,0,1.
      preload(2, 32'hAAAA_0002);
      preload(3, 32'hBBBB_0003);
      do_reset();
      ng = 0; nr = 0;
      @(posedge clk); #1;
      set_port(0, 1'b1, 32'h8, 32'h0, 4'h0);
      set_port(1, 1'b1, 32'hC, 32'h0, 4'h0);
      for (int c = 0; c < 30 && nr < 4; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            if (ng >= 4) req_valid = 2'b00;
         end
         @(negedge clk);
         if (req_ready != 2'b00) begin
            g_port.push_back(req_ready[1] ? 1 : 0); g_cyc.push_back(c); ng++;
         end
         if (rsp_valid != 2'b00) begin
            r_port.push_back(rsp_valid[1] ? 1 : 0); r_cyc.push_back(c);
            r_data.push_back(rsp_rdata); nr++;
         end
      end
      chk("tie_grant_count", 32'(g_port.size()), 32'd4);
      chk("tie_rsp_count", 32'(r_port.size()), 32'd4);
      for (int k = 0; k < 4 && k < g_port.size() && k < r_port.size(); k++) begin
         chk($sformatf("tie_grant%0d", k), 32'(g_port[k]), 32'(k % 2));
         chk($sformatf("tie_rsp_port%0d", k), 32'(r_port[k]), 32'(k % 2));
         chk($sformatf("tie_latency%0d", k), 32'(r_cyc[k] - g_cyc[k]), 32'd2);
         chk($sformatf("tie_rdata%0d", k), r_data[k],
             (k % 2 == 0) ? 32'hAAAA_0002 : 32'hBBBB_0003);
      end

      // Reset asserted during ACCESS of a write: nothing reaches the SRAM, no response.
      @(posedge clk); #1;
      req_valid = 2'b00;
      preload(2, 32'h1111_1111);
      @(posedge clk); #1;
      set_port(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF);
      @(negedge clk);
      chk("rstmid_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      chk("rstmid_in_access", 32'(mem_en), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_mem_en", 32'(mem_en), 32'h0);
      chk("rstmid_mem_addr", 32'(mem_addr), 32'h0);
      chk("rstmid_mem_wdata", mem_wdata, 32'h0);
      chk("rstmid_mem_wstrb", 32'(mem_wstrb), 32'h0);
      chk("rstmid_req_ready", 32'(req_ready), 32'h0);
      req_valid = 2'b00;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rstmid_no_rsp", 32'(rsp_valid), 32'h0);
      end
      chk("rstmid_sram2", sram[2], 32'h1111_1111);
      @(negedge clk);
      rst_n = 1'b1;
      do_txn("post_rst", 0, 32'h8, 32'h0, 4'h0, 1'b1, 32'h1111_1111);

      // Randomized traffic against a transaction-level model.
      for (int i = 0; i < 64; i++) begin
         ref_mem[i] = $urandom;
         preload(i, ref_mem[i]);
      end
      ref_last = 0;
      next_free = 0;
      pv[0] = 1'b0; pv[1] = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            if (!pv[p] && c < 380 && $urandom_range(0, 3) != 0) begin
               pv[p] = 1'b1;
               pa[p] = ($urandom_range(0, 9) == 0) ? ($urandom | 32'hFFFF_0000)
                                                   : 32'($urandom_range(0, 'h13F));
               pd[p] = $urandom;
               ps[p] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end
            set_port(p, pv[p], pa[p], pd[p], ps[p]);
         end
         @(negedge clk);
         exp_v = 2'b00; exp_d = 32'h0;
         if (rq.size() > 0 && rq[0].due == c) begin
            r = rq.pop_front();
            exp_v[r.port] = 1'b1;
            exp_d = r.rdata;
         end
         chk("rand_rsp_valid", 32'(rsp_valid), 32'(exp_v));
         if (exp_v != 2'b00) chk("rand_rsp_rdata", rsp_rdata, exp_d);
         exp_r = 2'b00;
         w = 0;
         if (c >= next_free && (pv[0] || pv[1])) begin
            w = (pv[0] && pv[1]) ? 1 - ref_last : (pv[1] ? 1 : 0);
            exp_r[w] = 1'b1;
         end
         chk("rand_req_ready", 32'(req_ready), 32'(exp_r));
         if (exp_r != 2'b00) begin
            r.due = c + 2; r.port = w; r.rdata = 32'h0;
            if (pa[w] < 32'd256) begin
               if (ps[w] == 4'h0) r.rdata = ref_mem[pa[w][7:2]];
               else ref_mem[pa[w][7:2]] = merge(ref_mem[pa[w][7:2]], pd[w], ps[w]);
            end
            rq.push_back(r);
            pv[w] = 1'b0;
            next_free = c + 3;
            ref_last = w;
         end
      end
      chk("rand_drain", 32'(rq.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule
